// File: rtl/elec_config_mlane_serializer.sv
// elec_config_mlane_serializer
//
// Double-buffered, multi-lane shifter for the electrode configuration word.
// The controller stages a word with load_req, then starts a frame with start.
// The frame shifts the word out over N_LANES serial lanes that share sclk,
// pulses latch, and then pulses sr_finish.
//
// Ports
//   clock          system clock; all logic runs on the rising edge
//   rst_n          asynchronous active-low reset
//   elec_config    configuration word to stage (N_ELECTRODES bits)
//   load_req       pulse: copy elec_config into the staging register
//   load_ack       pulse, one cycle after load_req
//   start          pulse: begin a frame (ignored unless idle)
//   busy           frame in progress
//   sr_finish      pulse in the last cycle of a frame
//   enable_config  high while lane data is being shifted
//   sclk           shared shift clock to the external chains
//   sdata          one serial data bit per lane
//   latch          latch strobe to the external chains
//   sdin_rb        chain return data, one bit per lane
//   rb_mismatch    sticky readback error flag
//
// Optional feature: define SER_READBACK_EN to capture sdin_rb during each
// frame and compare it with the previous frame's content. Without the macro,
// sdin_rb is ignored and rb_mismatch is tied low.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for start
// S_SHIFT_LO| sclk low, sdata presents the current bit
// S_SHIFT_HI| sclk high, external registers have clocked the bit
// S_LATCH   | latch strobe high, lanes driven low
// S_DONE    | single-cycle sr_finish
module elec_config_mlane_serializer #(
  parameter int N_ELECTRODES = 129,
  parameter int N_LANES      = 4,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [N_ELECTRODES-1:0] elec_config,
  input  logic                    load_req,
  output logic                    load_ack,
  input  logic                    start,
  output logic                    busy,
  output logic                    sr_finish,
  output logic                    enable_config,
  output logic                    sclk,
  output logic [N_LANES-1:0]      sdata,
  output logic                    latch,
  input  logic [N_LANES-1:0]      sdin_rb,
  output logic                    rb_mismatch
);

  localparam int L  = (N_ELECTRODES + N_LANES - 1) / N_LANES;
  localparam int W  = L * N_LANES;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(L - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                  state;
  logic [N_ELECTRODES-1:0] pend;
  logic [W-1:0]            sreg;
  logic [W-1:0]            pend_pad;
  logic [W-1:0]            sreg_shifted;
  logic [CW-1:0]           bit_cnt;
  logic [TW-1:0]           tmr;

  // Indices at or above N_ELECTRODES are padding and always shift out as 0.
  assign pend_pad = W'(pend);

  // Each lane occupies L contiguous bits of sreg; its top bit is on the wire.
  // Zero fill means sreg is all-zero once a frame has shifted out, which is
  // what keeps sdata low during LATCH, DONE and IDLE.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    if (L > 1) begin : g_multi
      assign sreg_shifted[k*L +: L] = {sreg[k*L +: L-1], 1'b0};
    end else begin : g_single
      assign sreg_shifted[k*L] = 1'b0;
    end
    assign sdata[k] = sreg[k*L + L - 1];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pend          <= '0;
      sreg          <= '0;
      bit_cnt       <= '0;
      tmr           <= '0;
      load_ack      <= 1'b0;
      busy          <= 1'b0;
      enable_config <= 1'b0;
      sclk          <= 1'b0;
      latch         <= 1'b0;
      sr_finish     <= 1'b0;
    end else begin
      load_ack  <= load_req;
      sr_finish <= 1'b0;
      if (load_req) begin
        pend <= elec_config;
      end
      case (state)
        S_IDLE: begin
          // sreg takes the pre-load pend when load_req and start coincide.
          if (start) begin
            sreg          <= pend_pad;
            bit_cnt       <= '0;
            tmr           <= TMR_LOAD;
            busy          <= 1'b1;
            enable_config <= 1'b1;
            state         <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (tmr == '0) begin
            tmr   <= TMR_LOAD;
            sclk  <= 1'b1;
            state <= S_SHIFT_HI;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (tmr == '0) begin
            tmr  <= TMR_LOAD;
            sclk <= 1'b0;
            sreg <= sreg_shifted;
            if (bit_cnt == LAST_BIT) begin
              enable_config <= 1'b0;
              latch         <= 1'b1;
              state         <= S_LATCH;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              state   <= S_SHIFT_LO;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_LATCH: begin
          if (tmr == '0) begin
            latch     <= 1'b0;
            sr_finish <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy          <= 1'b0;
          enable_config <= 1'b0;
          sclk          <= 1'b0;
          latch         <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SER_READBACK_EN
  // The chain returns the previous frame while the current one shifts in, so
  // the capture is compared with a copy of the frame before the current one.
  logic [W-1:0] cur_frame;
  logic [W-1:0] prev_frame;
  logic [W-1:0] rb_cap;
  logic [W-1:0] rb_cap_next;
  logic         have_prev;
  logic         rb_arm;

  for (genvar k = 0; k < N_LANES; k++) begin : g_rb
    if (L > 1) begin : g_multi
      assign rb_cap_next[k*L +: L] = {rb_cap[k*L +: L-1], sdin_rb[k]};
    end else begin : g_single
      assign rb_cap_next[k*L] = sdin_rb[k];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_frame   <= '0;
      prev_frame  <= '0;
      rb_cap      <= '0;
      have_prev   <= 1'b0;
      rb_arm      <= 1'b0;
      rb_mismatch <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        prev_frame  <= cur_frame;
        cur_frame   <= pend_pad;
        rb_arm      <= have_prev;
        have_prev   <= 1'b1;
        rb_mismatch <= 1'b0;
      end
      // Sample on the last high-phase cycle, after the chain has clocked.
      if (state == S_SHIFT_HI && tmr == '0) begin
        rb_cap <= rb_cap_next;
      end
      // Set on entry to DONE so the flag is visible alongside sr_finish.
      if (state == S_LATCH && tmr == '0 && rb_arm && rb_cap != prev_frame) begin
        rb_mismatch <= 1'b1;
      end
    end
  end
`else
  logic unused_rb;
  assign unused_rb   = ^sdin_rb;
  assign rb_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_elec_config_mlane_serializer.sv
// Self-checking bench for elec_config_mlane_serializer (9 electrodes, 2 lanes,
// CLK_DIV=2). A frame-position model predicts every output each cycle; directed
// frames pin lane bit sequences, frame length and latch width to literals.
// Build with SER_READBACK_EN defined to exercise the readback path.
module tb_elec_config_mlane_serializer;

  localparam int NE = 9;
  localparam int NL = 2;
  localparam int CD = 2;
  localparam int L  = (NE + NL - 1) / NL;
  localparam int F  = 2 * CD * L + CD + 1;

`ifdef SER_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic          clock;
  logic          rst_n;
  logic [NE-1:0] elec_config;
  logic          load_req;
  logic          load_ack;
  logic          start;
  logic          busy;
  logic          sr_finish;
  logic          enable_config;
  logic          sclk;
  logic [NL-1:0] sdata;
  logic          latch;
  logic [NL-1:0] sdin_rb;
  logic          rb_mismatch;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit corrupt_frame = 1'b0;

  elec_config_mlane_serializer #(
    .N_ELECTRODES(NE),
    .N_LANES     (NL),
    .CLK_DIV     (CD)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .elec_config  (elec_config),
    .load_req     (load_req),
    .load_ack     (load_ack),
    .start        (start),
    .busy         (busy),
    .sr_finish    (sr_finish),
    .enable_config(enable_config),
    .sclk         (sclk),
    .sdata        (sdata),
    .latch        (latch),
    .sdin_rb      (sdin_rb),
    .rb_mismatch  (rb_mismatch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame position ----------------
  logic [NE-1:0] m_pend;
  logic [NE-1:0] m_frame;
  int            m_pos;
  logic          m_ack;
  logic          m_had;
  logic          m_arm;
  logic          m_bad;
  logic          m_rb;
  logic [NL-1:0] corrupt_mask;

  // Invert lane 0's returned bit while bit 2 of a corrupted frame is on the wire.
  assign corrupt_mask = {1'b0, (corrupt_frame && m_pos >= 0 && (m_pos / (2 * CD)) == 2)};

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= '0;
      m_frame <= '0;
      m_pos   <= -1;
      m_ack   <= 1'b0;
      m_had   <= 1'b0;
      m_arm   <= 1'b0;
      m_bad   <= 1'b0;
      m_rb    <= 1'b0;
    end else begin
      m_ack <= load_req;
      if (load_req) m_pend <= elec_config;
      if (m_pos < 0) begin
        if (start) begin
          m_pos   <= 0;
          m_frame <= m_pend;
          m_arm   <= m_had;
          m_had   <= 1'b1;
          m_bad   <= 1'b0;
          m_rb    <= 1'b0;
        end
      end else begin
        if (corrupt_mask != '0) m_bad <= 1'b1;
        if (m_pos == F - 2 && m_arm && m_bad) m_rb <= 1'b1;
        m_pos <= (m_pos == F - 1) ? -1 : m_pos + 1;
      end
    end
  end

  typedef struct packed {
    logic          busy;
    logic          en;
    logic          sclk;
    logic          latch;
    logic          fin;
    logic [NL-1:0] sd;
  } exp_t;

  function automatic exp_t exp_out(input int p, input logic [NE-1:0] fr);
    exp_t e;
    e = '0;
    if (p >= 0) begin
      e.busy = 1'b1;
      if (p < 2 * CD * L) begin
        int b;
        b      = p / (2 * CD);
        e.en   = 1'b1;
        e.sclk = ((p % (2 * CD)) >= CD);
        for (int k = 0; k < NL; k++) begin
          int idx;
          idx     = k * L + (L - 1 - b);
          e.sd[k] = (idx < NE) ? fr[idx] : 1'b0;
        end
      end else if (p < 2 * CD * L + CD) begin
        e.latch = 1'b1;
      end else begin
        e.fin = 1'b1;
      end
    end
    return e;
  endfunction

  exp_t ev;
  always @(negedge clock) begin
    if (chk_en && rst_n) begin
      ev = exp_out(m_pos, m_frame);
      check("busy",          busy,          ev.busy);
      check("enable_config", enable_config, ev.en);
      check("sclk",          sclk,          ev.sclk);
      check("sdata",         sdata,         ev.sd);
      check("latch",         latch,         ev.latch);
      check("sr_finish",     sr_finish,     ev.fin);
      check("load_ack",      load_ack,      m_ack);
      check("rb_mismatch",   rb_mismatch,   RB_EN ? m_rb : 1'b0);
    end
  end

  // ---------------- external chain loopback (one return flop per lane) ----------------
  logic [L-1:0]  chain0 = '0;
  logic [L-1:0]  chain1 = '0;
  logic [NL-1:0] rb_out = '0;
  always @(posedge sclk) begin
    rb_out <= {chain1[L-1], chain0[L-1]};
    chain0 <= {chain0[L-2:0], sdata[0]};
    chain1 <= {chain1[L-2:0], sdata[1]};
  end
  assign sdin_rb = rb_out ^ corrupt_mask;

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [NE-1:0] v);
    @(negedge clock);
    load_req    = 1'b1;
    elec_config = v;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_frame(input bit ld_at_start, input logic [NE-1:0] ld_val,
                           input bit mid, input logic [NE-1:0] mid_val,
                           output int fin, output logic [L-1:0] l0, output logic [L-1:0] l1,
                           output int rises, output int lat,
                           output logic rb_pre, output logic rb_first, output logic rb_fin);
    logic prev_s;
    @(negedge clock);
    rb_pre = rb_mismatch;
    start  = 1'b1;
    if (ld_at_start) begin
      load_req    = 1'b1;
      elec_config = ld_val;
    end
    @(negedge clock);
    start    = 1'b0;
    load_req = 1'b0;
    fin      = -1;
    l0       = '0;
    l1       = '0;
    rises    = 0;
    lat      = 0;
    prev_s   = 1'b0;
    rb_first = rb_mismatch;
    rb_fin   = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clock);
      if (sclk && !prev_s) begin
        rises++;
        l0 = {l0[L-2:0], sdata[0]};
        l1 = {l1[L-2:0], sdata[1]};
      end
      prev_s = sclk;
      if (latch) lat++;
      start    = mid && (n == 6);
      load_req = mid && (n == 6);
      if (mid && n == 6) elec_config = mid_val;
      if (sr_finish) begin
        fin    = n;
        rb_fin = rb_mismatch;
        break;
      end
    end
    start    = 1'b0;
    load_req = 1'b0;
  endtask

  int            fin;
  int            rises;
  int            lat;
  logic [L-1:0]  l0;
  logic [L-1:0]  l1;
  logic          rb_pre;
  logic          rb_first;
  logic          rb_fin;

  initial begin
    rst_n       = 1'b0;
    elec_config = '0;
    load_req    = 1'b0;
    start       = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy",      busy,          0);
    check("rst_sclk",      sclk,          0);
    check("rst_sdata",     sdata,         0);
    check("rst_latch",     latch,         0);
    check("rst_finish",    sr_finish,     0);
    check("rst_load_ack",  load_ack,      0);
    check("rst_enable",    enable_config, 0);
    check("rst_rb",        rb_mismatch,   0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // load then observe the one-cycle ack
    @(negedge clock);
    load_req    = 1'b1;
    elec_config = 9'h1A5;
    @(negedge clock);
    load_req = 1'b0;
    check("load_ack_pulse", load_ack, 1);
    @(negedge clock);
    check("load_ack_clear", load_ack, 0);

    // frame with 9'h1A5
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f1_len",     fin,   23);
    check("f1_rises",   rises, 5);
    check("f1_latch",   lat,   2);
    check("f1_lane0",   l0,    5'b00101);
    check("f1_lane1",   l1,    5'b01101);

    // mid-frame start is ignored; mid-frame load does not disturb the frame
    run_frame(0, '0, 1, 9'h0FF, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f2_len",     fin,   23);
    check("f2_lane0",   l0,    5'b00101);
    check("f2_lane1",   l1,    5'b01101);

    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f3_lane0",   l0,    5'b11111);
    check("f3_lane1",   l1,    5'b00111);

    // load and start together: old pend now, new pend next frame
    run_frame(1, 9'h001, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f4_lane0",   l0,    5'b11111);
    check("f4_lane1",   l1,    5'b00111);
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f5_lane0",   l0,    5'b00001);
    check("f5_lane1",   l1,    5'b00000);

    // reset in cycle 7 of a frame
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   busy,          0);
    check("mid_rst_sclk",   sclk,          0);
    check("mid_rst_sdata",  sdata,         0);
    check("mid_rst_latch",  latch,         0);
    check("mid_rst_enable", enable_config, 0);
    check("mid_rst_finish", sr_finish,     0);
    repeat (2) @(negedge clock);
    check("rst_no_latch", latch, 0);
    #2 rst_n = 1'b1;
    do_load(9'h155);
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("f6_len",     fin,   23);
    check("f6_lane0",   l0,    5'b10101);
    check("f6_lane1",   l1,    5'b01010);

    // readback: first frame unchecked, second clean, third corrupted, fourth clears
    do_reset();
    do_load(9'h1A5);
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("rb_clean", rb_fin, 0);
    corrupt_frame = 1'b1;
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    corrupt_frame = 1'b0;
    check("rb_corrupt_done", rb_fin, RB_EN);
    run_frame(0, '0, 0, '0, fin, l0, l1, rises, lat, rb_pre, rb_first, rb_fin);
    check("rb_sticky_idle", rb_pre,   RB_EN);
    check("rb_clear_start", rb_first, 0);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      start       = ($urandom_range(0, 9) == 0);
      load_req    = ($urandom_range(0, 5) == 0);
      elec_config = NE'($urandom);
    end
    @(negedge clock);
    start    = 1'b0;
    load_req = 1'b0;
    repeat (30) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
